// File: rtl/approx_mul_fixup.sv
// Post-processing for the approximate FP32 multiplier: specials, exponent range fixup, FTZ, exception counters.
// Latency 2 cycles, 1/cycle throughput; valid/ready with full hold of both stages on out_ready=0.
module approx_mul_fixup #(
    parameter int          CNT_W = 16,
    parameter int          BIAS  = 127,
    parameter logic [31:0] QNAN  = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [31:0]      raw_y,
    input  logic [1:0]       norm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [3:0]       flags,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] nan_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] unf_cnt
);

    logic              w_adv1, w_adv2, w_in_hs, w_out_hs;
    logic [7:0]        w_ea, w_eb;
    logic              w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic signed [10:0] w_ew;
    logic              w_unused_raw;

    logic              r_s1_valid;
    logic              r_s1_sgn;
    logic              r_s1_inv;
    logic              r_s1_inf;
    logic              r_s1_zero;
    logic signed [10:0] r_s1_ew;
    logic [22:0]       r_s1_man;

    logic              r_s2_valid;
    logic [31:0]       r_y;
    logic [3:0]        r_flags;
    logic [31:0]       w_y;
    logic [3:0]        w_flags;

    logic [CNT_W-1:0]  r_nan_cnt, r_ovf_cnt, r_unf_cnt;
    logic [CNT_W-1:0]  w_one;

    assign w_adv2   = !r_s2_valid | out_ready;
    assign w_adv1   = !r_s1_valid | w_adv2;
    assign in_ready = w_adv1;
    assign w_in_hs  = in_valid & w_adv1;
    assign w_out_hs = r_s2_valid & out_ready;

    // Only the mantissa of the core's raw result is trusted; its exponent may have wrapped.
    assign w_unused_raw = ^raw_y[31:23];

    assign w_ea     = a[30:23];
    assign w_eb     = b[30:23];
    assign w_zero_a = (w_ea == 8'd0);
    assign w_zero_b = (w_eb == 8'd0);
    assign w_inf_a  = (w_ea == 8'hFF) && (a[22:0] == 23'd0);
    assign w_inf_b  = (w_eb == 8'hFF) && (b[22:0] == 23'd0);
    assign w_nan_a  = (w_ea == 8'hFF) && (a[22:0] != 23'd0);
    assign w_nan_b  = (w_eb == 8'hFF) && (b[22:0] != 23'd0);

    // 11 bits cover -127..386, so the sum never wraps.
    assign w_ew = $signed(11'(w_ea) + 11'(w_eb) + 11'(norm) - 11'(BIAS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sgn   <= 1'b0;
            r_s1_inv   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_ew    <= '0;
            r_s1_man   <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (w_in_hs) begin
                r_s1_sgn  <= a[31] ^ b[31];
                r_s1_inv  <= w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
                r_s1_inf  <= w_inf_a | w_inf_b;
                r_s1_zero <= w_zero_a | w_zero_b;
                r_s1_ew   <= w_ew;
                r_s1_man  <= raw_y[22:0];
            end
        end
    end

    // flags = {invalid, overflow, underflow, special}; priority order matters.
    always_comb begin
        w_y     = {r_s1_sgn, r_s1_ew[7:0], r_s1_man};
        w_flags = 4'b0000;
        if (r_s1_inv) begin
            w_y     = QNAN;
            w_flags = 4'b1000;
        end else if (r_s1_inf) begin
            w_y     = {r_s1_sgn, 8'hFF, 23'd0};
            w_flags = 4'b0001;
        end else if (r_s1_zero) begin
            w_y     = {r_s1_sgn, 31'd0};
            w_flags = 4'b0001;
        end else if (r_s1_ew >= 11'sd255) begin
            w_y     = {r_s1_sgn, 8'hFF, 23'd0};
            w_flags = 4'b0100;
        end else if (r_s1_ew <= 11'sd0) begin
            w_y     = {r_s1_sgn, 31'd0};
            w_flags = 4'b0010;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_flags    <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y     <= w_y;
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign y         = r_y;
    assign flags     = r_flags;

    assign w_one = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_nan_cnt <= '0;
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_flags[3] && !(&r_nan_cnt)) r_nan_cnt <= r_nan_cnt + w_one;
            if (r_flags[2] && !(&r_ovf_cnt)) r_ovf_cnt <= r_ovf_cnt + w_one;
            if (r_flags[1] && !(&r_unf_cnt)) r_unf_cnt <= r_unf_cnt + w_one;
        end
    end

    assign nan_cnt = r_nan_cnt;
    assign ovf_cnt = r_ovf_cnt;
    assign unf_cnt = r_unf_cnt;

endmodule

// File: tb/tb_approx_mul_fixup.sv
// Scoreboard bench for approx_mul_fixup: a 16-bit-counter instance and a 2-bit-counter instance share stimulus.
module tb_approx_mul_fixup;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, cnt_clr;
    logic [31:0] a, b, raw_y;
    logic [1:0]  norm;

    logic        in_ready, out_valid;
    logic [31:0] y;
    logic [3:0]  flags;
    logic [15:0] nan_cnt, ovf_cnt, unf_cnt;

    logic        in_ready_s, out_valid_s;
    logic [31:0] y_s;
    logic [3:0]  flags_s;
    logic [1:0]  nan_s, ovf_s, unf_s;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 0;
    int m_nan16 = 0, m_ovf16 = 0, m_unf16 = 0;
    int m_nan2 = 0, m_ovf2 = 0, m_unf2 = 0;
    logic [35:0] sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    approx_mul_fixup u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .raw_y(raw_y), .norm(norm),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .flags(flags),
        .cnt_clr(cnt_clr), .nan_cnt(nan_cnt), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
    );

    approx_mul_fixup #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .raw_y(raw_y), .norm(norm),
        .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .flags(flags_s),
        .cnt_clr(cnt_clr), .nan_cnt(nan_s), .ovf_cnt(ovf_s), .unf_cnt(unf_s)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Returns {flags, y}
    function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [31:0] mraw, input logic [1:0] mn);
        int   ea = int'(ma[30:23]);
        int   eb = int'(mb[30:23]);
        bit   za = (ea == 0);
        bit   zb = (eb == 0);
        bit   ia = (ea == 255) && (ma[22:0] == 23'd0);
        bit   ib = (eb == 255) && (mb[22:0] == 23'd0);
        bit   na = (ea == 255) && (ma[22:0] != 23'd0);
        bit   nb = (eb == 255) && (mb[22:0] != 23'd0);
        int   ew = ea + eb - 127 + int'(mn);
        logic s  = ma[31] ^ mb[31];
        if (na || nb || (ia && zb) || (za && ib)) return {4'b1000, 32'h7FC00000};
        if (ia || ib)  return {4'b0001, s, 8'hFF, 23'd0};
        if (za || zb)  return {4'b0001, s, 31'd0};
        if (ew >= 255) return {4'b0100, s, 8'hFF, 23'd0};
        if (ew <= 0)   return {4'b0010, s, 31'd0};
        return {4'b0000, s, ew[7:0], mraw[22:0]};
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    // Monitor: samples at negedge, models the next rising edge.
    always @(negedge clk) begin
        logic [35:0] e;
        if (mon_en) begin
            check_eq("nan_cnt", nan_cnt, m_nan16);
            check_eq("ovf_cnt", ovf_cnt, m_ovf16);
            check_eq("unf_cnt", unf_cnt, m_unf16);
            check_eq("nan_cnt_w2", nan_s, m_nan2);
            check_eq("ovf_cnt_w2", ovf_s, m_ovf2);
            check_eq("unf_cnt_w2", unf_s, m_unf2);
            if (rst) begin
                sbq.delete();
                m_nan16 = 0; m_ovf16 = 0; m_unf16 = 0;
                m_nan2 = 0;  m_ovf2 = 0;  m_unf2 = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        check_eq("unexpected_output", sbq.size(), 1);
                    end else begin
                        e = sbq.pop_front();
                        check_eq("y", y, e[31:0]);
                        check_eq("flags", flags, e[35:32]);
                        check_eq("y_w2", y_s, e[31:0]);
                        check_eq("flags_w2", flags_s, e[35:32]);
                        if (e[35]) begin m_nan16 = sat_inc(m_nan16, 65535); m_nan2 = sat_inc(m_nan2, 3); end
                        if (e[34]) begin m_ovf16 = sat_inc(m_ovf16, 65535); m_ovf2 = sat_inc(m_ovf2, 3); end
                        if (e[33]) begin m_unf16 = sat_inc(m_unf16, 65535); m_unf2 = sat_inc(m_unf2, 3); end
                    end
                end
                if (cnt_clr) begin
                    m_nan16 = 0; m_ovf16 = 0; m_unf16 = 0;
                    m_nan2 = 0;  m_ovf2 = 0;  m_unf2 = 0;
                end
                if (in_valid && in_ready) sbq.push_back(model(a, b, raw_y, norm));
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] traw, input logic [1:0] tn);
        bit acc = 0;
        a = ta; b = tb_v; raw_y = traw; norm = tn; in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) check_eq("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sbq.size() != 0 || out_valid) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("drain", sbq.size(), 0);
    endtask

    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    logic [35:0] e0, e3;
    int t0, idx;

    initial begin
        rst = 1; in_valid = 0; out_ready = 1; cnt_clr = 0;
        a = 0; b = 0; raw_y = 0; norm = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        mon_en = 1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_valid_w2", out_valid_s, 0);
        check_eq("rst_y", y, 0);
        check_eq("rst_flags", flags, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_in_ready_w2", in_ready_s, 1);

        // Normal product and latency
        send(32'h3FC00000, 32'h40000000, 32'h00400000, 2'd0);
        check_eq("lat_1cyc", out_valid, 0);
        @(posedge clk); #1;
        check_eq("lat_2cyc", out_valid, 1);
        check_eq("lat_2cyc_w2", out_valid_s, 1);
        check_eq("normal_y", y, 32'h40400000);

        // Directed special / range cases, back to back
        send(32'h7F000000, 32'h7F000000, 32'h00000000, 2'd0);
        send(32'hFF000000, 32'h7F000000, 32'h00000000, 2'd0);
        send(32'h80800000, 32'h00800000, 32'h00123456, 2'd0);
        send(32'h00400000, 32'h3F800000, 32'h00000000, 2'd0);
        send(32'h7F800000, 32'h00000000, 32'h00000000, 2'd0);
        send(32'h7FA00000, 32'h3F800000, 32'h00000000, 2'd0);
        send(32'hFF800000, 32'h3F800000, 32'h00000000, 2'd1);
        send(32'h3F800000, 32'h00000000, 32'h00000000, 2'd0);
        send(32'h43000000, 32'h3C000000, 32'h007FFFFF, 2'd3);
        send(32'h7F000000, 32'h40000000, 32'h00000000, 2'd1);
        send(32'h00800000, 32'h3F000000, 32'h00000000, 2'd3);
        wait_drain();

        // Random burst at full rate
        t0 = cyc;
        for (int i = 0; i < 16; i++)
            send($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
        check_eq("throughput_cycles", cyc - t0, 16);
        wait_drain();

        // Backpressure: only two entries fit while out_ready is low
        bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        bp_b = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        e0 = model(bp_a[0], bp_b[0], 32'h00010000, 2'd0);
        e3 = model(bp_a[3], bp_b[3], 32'h00040000, 2'd0);
        out_ready = 0; idx = 0;
        for (int c = 0; c < 4; c++) begin
            bit acc;
            a = bp_a[idx]; b = bp_b[idx]; raw_y = 32'h00010000 * (idx + 1); norm = 0;
            in_valid = 1;
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (out_valid) check_eq("bp_hold_y", y, e0[31:0]);
        end
        check_eq("bp_accepted", idx, 2);
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_in_ready_w2", in_ready_s, 0);
        in_valid = 0;
        out_ready = 1;
        for (int i = idx; i < 4; i++) send(bp_a[i], bp_b[i], 32'h00010000 * (i + 1), 2'd0);
        wait_drain();
        repeat (2) @(posedge clk); #1;
        check_eq("idle_hold_y", y, e3[31:0]);
        check_eq("idle_hold_flags", flags, e3[35:32]);

        // Saturation of the narrow counters
        for (int i = 0; i < 5; i++) send(32'h7F000000, 32'h7F000000, 32'h0, 2'd0);
        wait_drain();
        @(posedge clk); #1;
        check_eq("ovf_sat_w2", ovf_s, 3);

        // Clear wins over a coincident overflow delivery
        send(32'h7F000000, 32'h7F000000, 32'h0, 2'd0);
        @(posedge clk); #1;
        cnt_clr = 1;
        @(posedge clk); #1;
        cnt_clr = 0;
        check_eq("clr_ovf", ovf_cnt, 0);
        check_eq("clr_ovf_w2", ovf_s, 0);

        // Build up counts, then reset with both stages full
        send(32'h7F800000, 32'h00000000, 32'h0, 2'd0);
        send(32'h80800000, 32'h00800000, 32'h0, 2'd0);
        wait_drain();
        out_ready = 0;
        send(32'h7F000000, 32'h7F000000, 32'h0, 2'd0);
        send(32'h3F800000, 32'h3F800000, 32'h0, 2'd0);
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_out_valid", out_valid, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        out_ready = 1;
        check_eq("rst2_out_valid", out_valid, 0);
        check_eq("rst2_y", y, 0);
        check_eq("rst2_nan", nan_cnt, 0);
        check_eq("rst2_ovf", ovf_cnt, 0);
        check_eq("rst2_unf", unf_cnt, 0);
        repeat (3) @(posedge clk); #1;
        check_eq("rst2_no_ghost", out_valid, 0);

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
